// File: rtl/motor_pkg.sv
// Shared motor command encodings, arbiter mode codes and FSM state type.
// Used by motor_cmd_arbiter and motor_controller.
package motor_pkg;

  localparam logic [2:0] MOTOR_STOP  = 3'd0;
  localparam logic [2:0] MOTOR_FWD   = 3'd1;
  localparam logic [2:0] MOTOR_BACK  = 3'd2;
  localparam logic [2:0] MOTOR_LEFT  = 3'd3;
  localparam logic [2:0] MOTOR_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_MAN  = 2'd1,
    MODE_AUTO = 2'd2,
    MODE_HOLD = 2'd3
  } arb_mode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAN  = 3'd1,
    S_AUTO = 3'd2,
    S_DEAD = 3'd3,
    S_HOLD = 3'd4
  } arb_state_e;

  // Unassigned codes 5..7 are never allowed to reach the motors.
  function automatic logic [2:0] motor_sanitize(input logic [2:0] cmd);
    case (cmd)
      MOTOR_STOP, MOTOR_FWD, MOTOR_BACK, MOTOR_LEFT, MOTOR_RIGHT: motor_sanitize = cmd;
      default: motor_sanitize = MOTOR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Saturating up-counter with synchronous clear and count enable; o_tc flags
// the cycle in which the count steps onto TERM (TERM must be >= 1).
module arb_timer #(
  parameter int unsigned TERM = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned W = $clog2(TERM + 1);
  localparam logic [W-1:0] LAST = W'(TERM - 1);
  localparam logic [W-1:0] FULL = W'(TERM);

  logic [W-1:0] r_count;
  logic         w_done;

  assign w_done = (r_count == FULL);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && !w_done) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tc = i_en && !i_clear && (r_count == LAST);

endmodule

// File: rtl/motor_cmd_arbiter.sv
// Arbitrates manual and auto motor commands with obstacle hold, manual watchdog
// and, when MOTOR_ARB_DEADTIME_EN is defined, direction-reversal dead-time.
module motor_cmd_arbiter
  import motor_pkg::*;
#(
  parameter int unsigned MAN_TIMEOUT_CYC = 50_000_000,
  parameter int unsigned DEADTIME_CYC    = 1_000_000,
  parameter int unsigned OBS_RELEASE_CYC = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       man_valid,
  input  logic [2:0] man_motor_state,
  input  logic       auto_en,
  input  logic [2:0] auto_motor_state,
  input  logic       obstacle_stop,
  output logic [2:0] motor_state,
  output logic [1:0] active_mode,
  output logic       deadtime_busy,
  output logic       fault_timeout
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  arb_state_e w_target;
  arb_mode_e  r_mode;
  arb_mode_e  w_next_mode;

  logic [2:0] r_motor_state;
  logic [2:0] r_man_cmd;
  logic [2:0] w_next_motor;
  logic [2:0] w_man_eff;
  logic [2:0] w_auto_cmd;
  logic [2:0] w_sel;
  logic       r_fault;
  logic       w_accept_man;
  logic       w_wd_tc;
  logic       w_dead_start;
  logic       w_dead_tc;
  logic       w_rel_tc;

  arb_timer #(.TERM(MAN_TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept_man),
    .i_en    ((r_state == S_MAN) && !obstacle_stop),
    .o_tc    (w_wd_tc)
  );

  arb_timer #(.TERM(DEADTIME_CYC)) u_deadtime (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_dead_start),
    .i_en    ((r_state == S_DEAD) && !obstacle_stop),
    .o_tc    (w_dead_tc)
  );

  arb_timer #(.TERM(OBS_RELEASE_CYC)) u_release (
    .clk     (clk),
    .rst     (rst),
    .i_clear (obstacle_stop),
    .i_en    (r_state == S_HOLD),
    .o_tc    (w_rel_tc)
  );

  // A fresh manual command bypasses the latch so it reaches the output in one cycle.
  assign w_accept_man = man_valid && (r_state != S_HOLD) && !obstacle_stop;
  assign w_man_eff    = w_accept_man ? motor_sanitize(man_motor_state) :
                        (w_wd_tc ? MOTOR_STOP : r_man_cmd);
  assign w_auto_cmd   = motor_sanitize(auto_motor_state);
  assign w_sel        = auto_en ? w_auto_cmd : w_man_eff;
  assign w_target     = auto_en ? S_AUTO : S_MAN;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_motor = r_motor_state;
    w_dead_start = 1'b0;
    if (obstacle_stop) begin
      w_next_state = S_HOLD;
      w_next_motor = MOTOR_STOP;
    end else begin
      case (r_state)
        S_HOLD: begin
          w_next_motor = MOTOR_STOP;
          if (w_rel_tc) w_next_state = S_IDLE;
        end
        S_IDLE: begin
          w_next_motor = MOTOR_STOP;
          w_next_state = w_target;
        end
        S_DEAD: begin
          w_next_motor = MOTOR_STOP;
          if (w_dead_tc) begin
            w_next_state = w_target;
            w_next_motor = w_sel;
          end
        end
        S_MAN, S_AUTO: begin
          w_next_state = w_target;
          w_next_motor = w_sel;
`ifdef MOTOR_ARB_DEADTIME_EN
          if ((w_sel != r_motor_state) && (w_sel != MOTOR_STOP) &&
              (r_motor_state != MOTOR_STOP)) begin
            w_next_state = S_DEAD;
            w_next_motor = MOTOR_STOP;
            w_dead_start = 1'b1;
          end
`endif
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_motor = MOTOR_STOP;
        end
      endcase
    end
  end

  // Dead-time reports the mode it will return to.
  always_comb begin
    w_next_mode = MODE_IDLE;
    case (w_next_state)
      S_MAN:   w_next_mode = MODE_MAN;
      S_AUTO:  w_next_mode = MODE_AUTO;
      S_HOLD:  w_next_mode = MODE_HOLD;
      S_DEAD:  w_next_mode = auto_en ? MODE_AUTO : MODE_MAN;
      default: w_next_mode = MODE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_motor_state <= MOTOR_STOP;
      r_man_cmd     <= MOTOR_STOP;
      r_mode        <= MODE_IDLE;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_motor_state <= w_next_motor;
      r_man_cmd     <= obstacle_stop ? MOTOR_STOP : w_man_eff;
      r_mode        <= w_next_mode;
      r_fault       <= w_wd_tc;
    end
  end

`ifdef MOTOR_ARB_DEADTIME_EN
  logic r_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next_state == S_DEAD);
    end
  end

  assign deadtime_busy = r_busy;
`else
  assign deadtime_busy = 1'b0;
`endif

  assign motor_state   = r_motor_state;
  assign active_mode   = r_mode;
  assign fault_timeout = r_fault;

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Self-checking bench for motor_cmd_arbiter: directed scenarios plus random
// stimulus compared every cycle against a behavioural reference model.
module tb_motor_cmd_arbiter;

  localparam int MAN_TO = 100;
  localparam int DEAD   = 10;
  localparam int REL    = 20;
`ifdef MOTOR_ARB_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_MAN  = 1;
  localparam int P_AUTO = 2;
  localparam int P_DEAD = 3;
  localparam int P_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       man_valid = 1'b0;
  logic [2:0] man_motor_state = 3'd0;
  logic       auto_en = 1'b0;
  logic [2:0] auto_motor_state = 3'd0;
  logic       obstacle_stop = 1'b0;
  logic [2:0] motor_state;
  logic [1:0] active_mode;
  logic       deadtime_busy;
  logic       fault_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int fault_seen = 0;
  int busy_seen = 0;

  // Reference model state
  int m_phase = P_IDLE;
  int m_motor = 0;
  int m_mode = 0;
  int m_busy = 0;
  int m_fault = 0;
  int m_man = 0;
  int m_wd = 0;
  int m_dead_left = 0;
  int m_quiet = 0;

  motor_cmd_arbiter #(
    .MAN_TIMEOUT_CYC (MAN_TO),
    .DEADTIME_CYC    (DEAD),
    .OBS_RELEASE_CYC (REL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .man_valid        (man_valid),
    .man_motor_state  (man_motor_state),
    .auto_en          (auto_en),
    .auto_motor_state (auto_motor_state),
    .obstacle_stop    (obstacle_stop),
    .motor_state      (motor_state),
    .active_mode      (active_mode),
    .deadtime_busy    (deadtime_busy),
    .fault_timeout    (fault_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit reached, run did not complete");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int legal(input logic [2:0] c);
    return (int'(c) <= 4) ? int'(c) : 0;
  endfunction

  // One clock edge of the arbiter rules, applied to the inputs present at that edge.
  task automatic model_step();
    int a;
    int sel;
    int target;
    if (!rst) begin
      m_phase = P_IDLE; m_motor = 0; m_mode = 0; m_busy = 0; m_fault = 0;
      m_man = 0; m_wd = 0; m_dead_left = 0; m_quiet = 0;
      return;
    end
    m_fault = 0;
    a = legal(auto_motor_state);
    target = auto_en ? P_AUTO : P_MAN;
    if (obstacle_stop) begin
      m_phase = P_HOLD;
      m_motor = 0;
      m_man = 0;
      m_quiet = 0;
    end else begin
      if (m_phase != P_HOLD && man_valid) begin
        m_man = legal(man_motor_state);
        m_wd = 0;
      end else if (m_phase == P_MAN && m_wd < MAN_TO) begin
        m_wd++;
        if (m_wd == MAN_TO) begin
          m_man = 0;
          m_fault = 1;
        end
      end
      sel = auto_en ? a : m_man;
      case (m_phase)
        P_HOLD: begin
          m_quiet++;
          if (m_quiet == REL) m_phase = P_IDLE;
        end
        P_IDLE: begin
          m_motor = 0;
          m_phase = target;
        end
        P_DEAD: begin
          m_dead_left--;
          if (m_dead_left == 0) begin
            m_phase = target;
            m_motor = sel;
          end
        end
        default: begin
          if (DT_EN && sel != m_motor && sel != 0 && m_motor != 0) begin
            m_phase = P_DEAD;
            m_dead_left = DEAD;
            m_motor = 0;
          end else begin
            m_motor = sel;
            m_phase = target;
          end
        end
      endcase
    end
    m_busy = (m_phase == P_DEAD) ? 1 : 0;
    case (m_phase)
      P_MAN:   m_mode = 1;
      P_AUTO:  m_mode = 2;
      P_HOLD:  m_mode = 3;
      P_DEAD:  m_mode = auto_en ? 2 : 1;
      default: m_mode = 0;
    endcase
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check("motor_state", motor_state, m_motor);
      check("active_mode", active_mode, m_mode);
      check("deadtime_busy", deadtime_busy, m_busy);
      check("fault_timeout", fault_timeout, m_fault);
      if (fault_timeout === 1'b1) fault_seen++;
      if (deadtime_busy === 1'b1) busy_seen++;
    end
  endtask

  task automatic send_man(input logic [2:0] cmd);
    man_valid = 1'b1;
    man_motor_state = cmd;
    tick(1);
    man_valid = 1'b0;
  endtask

  task automatic random_run(input int cycles, input int mv_div);
    for (int i = 0; i < cycles; i++) begin
      rst = ($urandom_range(0, 599) != 0);
      man_valid = ($urandom_range(0, mv_div - 1) == 0);
      man_motor_state = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 9) == 0) auto_motor_state = 3'($urandom_range(0, 7));
      if (obstacle_stop) obstacle_stop = ($urandom_range(0, 3) != 0);
      else obstacle_stop = ($urandom_range(0, 119) == 0);
      tick(1);
    end
    man_valid = 1'b0;
    obstacle_stop = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    // Reset held with active inputs
    rst = 1'b0; man_valid = 1'b1; man_motor_state = 3'd2;
    auto_en = 1'b1; auto_motor_state = 3'd3; obstacle_stop = 1'b1;
    tick(3);
    check("rst_motor", motor_state, 0);
    check("rst_mode", active_mode, 0);
    check("rst_flags", {deadtime_busy, fault_timeout}, 0);

    // Manual FWD then watchdog expiry
    man_valid = 1'b0; obstacle_stop = 1'b0; auto_en = 1'b0; rst = 1'b1;
    tick(2);
    send_man(3'd1);
    check("man_fwd", motor_state, 1);
    fault_seen = 0;
    tick(MAN_TO + 5);
    check("wd_stop", motor_state, 0);
    check("wd_fault_once", fault_seen, 1);

    // FWD -> BACK dead-time, then FWD -> STOP immediate
    send_man(3'd1);
    tick(3);
    busy_seen = 0;
    send_man(3'd2);
    tick(DEAD + 4);
    check("dead_len", busy_seen, DT_EN ? DEAD : 0);
    check("dead_back", motor_state, 2);
    send_man(3'd1);
    tick(DEAD + 2);
    check("back_fwd", motor_state, 1);
    send_man(3'd0);
    check("stop_imm", motor_state, 0);

    // Auto with obstacle hold and release debounce
    auto_en = 1'b1; auto_motor_state = 3'd3;
    tick(3);
    check("auto_left", motor_state, 3);
    obstacle_stop = 1'b1;
    tick(1);
    check("hold_stop", motor_state, 0);
    check("hold_mode", active_mode, 3);
    obstacle_stop = 1'b0; tick(15);
    obstacle_stop = 1'b1; tick(1);
    obstacle_stop = 1'b0; tick(REL - 1);
    check("still_hold", active_mode, 3);
    tick(1);
    check("release_idle", active_mode, 0);
    tick(2);
    check("resume_auto", motor_state, 3);

    // Illegal auto code, then auto RIGHT -> manual LEFT through dead-time
    auto_motor_state = 3'd6;
    tick(2);
    check("illegal_stop", motor_state, 0);
    auto_motor_state = 3'd4;
    tick(2);
    check("auto_right", motor_state, 4);
    send_man(3'd3);
    tick(1);
    check("latched_in_auto", motor_state, 4);
    busy_seen = 0;
    auto_en = 1'b0;
    tick(DEAD + 2);
    check("switch_dead_len", busy_seen, DT_EN ? DEAD : 0);
    check("switch_left", motor_state, 3);

    // Randomized traffic: frequent manual commands, then sparse ones to hit the watchdog
    random_run(3000, 8);
    random_run(3000, 160);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
